// File: rtl/ring_pkg.sv
// Shared definitions for ring-sequence consumers: FSM states, default sizes,
// and the rotate-right step that defines the legal ring progression.
package ring_pkg;

    localparam int N_DEF     = 4;
    localparam int CNT_W_DEF = 8;
    localparam int MAX_N     = 32;

    typedef enum logic [1:0] {
        SYNC  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } state_e;

    // Rotate the low n bits of v right by one; bit 0 wraps into bit n-1.
    function automatic logic [MAX_N-1:0] rotr(input logic [MAX_N-1:0] v, input int n);
        logic [MAX_N-1:0] w_wrap;
        w_wrap = {{(MAX_N-1){1'b0}}, v[0]};
        return (v >> 1) | (w_wrap << (n - 1));
    endfunction

endpackage

// File: rtl/onehot_enc.sv
// One-hot checker/encoder: flags exactly-one-set and gives the binary index.
// Latency: combinational. Backpressure: none.
module onehot_enc #(
    parameter int N = 4
) (
    input  logic [N-1:0]         i_vec,
    output logic                 o_legal,
    output logic [$clog2(N)-1:0] o_idx
);
    localparam int IDX_W = $clog2(N);
    localparam int CW    = $clog2(N + 1);

    logic [CW-1:0] w_cnt;

    // OR-ing indices is only meaningful when o_legal is set.
    always_comb begin
        w_cnt = '0;
        o_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (i_vec[i]) begin
                w_cnt = w_cnt + CW'(1);
                o_idx = o_idx | IDX_W'(i);
            end
        end
    end

    assign o_legal = (w_cnt == CW'(1));

endmodule

// File: rtl/ring_slot_ctrl.sv
// Turns the one-hot ring phase into a registered per-slot grant, counts rotations,
// and traps broken ring sequences. Latency: one cycle. Backpressure: none (req is a level).
module ring_slot_ctrl
    import ring_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         phase,
    input  logic [N-1:0]         req,
    input  logic                 clr_err,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] slot_idx,
    output logic                 slot_vld,
    output logic [CNT_W-1:0]     rot_cnt,
    output logic                 err
);
    localparam int           IDX_W = $clog2(N);
    localparam logic [N-1:0] MSB   = {1'b1, {(N-1){1'b0}}};

    state_e             r_state, w_state_nxt;
    logic [N-1:0]       r_prev;
    logic [N-1:0]       r_gnt, w_gnt_nxt;
    logic [IDX_W-1:0]   r_idx, w_idx_nxt;
    logic               r_vld, w_vld_nxt;
    logic [CNT_W-1:0]   r_rot, w_rot_nxt;
    logic               r_err, w_err_nxt;

    logic               w_legal;
    logic [IDX_W-1:0]   w_idx;
    logic [N-1:0]       w_exp;

    onehot_enc #(.N(N)) u_enc (
        .i_vec   (phase),
        .o_legal (w_legal),
        .o_idx   (w_idx)
    );

    assign w_exp = N'(rotr(MAX_N'(r_prev), N));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= SYNC;
            r_prev  <= '0;
            r_gnt   <= '0;
            r_idx   <= '0;
            r_vld   <= 1'b0;
            r_rot   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_prev  <= phase;
            r_gnt   <= w_gnt_nxt;
            r_idx   <= w_idx_nxt;
            r_vld   <= w_vld_nxt;
            r_rot   <= w_rot_nxt;
            r_err   <= w_err_nxt;
        end
    end

    // Grant defaults to zero so any non-RUN outcome, including a fault, blocks it.
    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = '0;
        w_vld_nxt   = 1'b0;
        w_idx_nxt   = r_idx;
        w_rot_nxt   = r_rot;
        w_err_nxt   = r_err;
        case (r_state)
            SYNC: begin
                if (phase == MSB) begin
                    w_state_nxt = RUN;
                    w_gnt_nxt   = phase & req;
                    w_vld_nxt   = 1'b1;
                    w_idx_nxt   = w_idx;
                    w_rot_nxt   = '0;
                end
            end
            RUN: begin
                if (w_legal && (phase == w_exp)) begin
                    w_gnt_nxt = phase & req;
                    w_vld_nxt = 1'b1;
                    w_idx_nxt = w_idx;
                    if (phase == MSB) begin
                        w_rot_nxt = r_rot + CNT_W'(1);
                    end
                end else begin
                    w_state_nxt = FAULT;
                    w_err_nxt   = 1'b1;
                end
            end
            FAULT: begin
                if (clr_err) begin
                    w_state_nxt = SYNC;
                    w_err_nxt   = 1'b0;
                end
            end
            default: begin
                w_state_nxt = SYNC;
            end
        endcase
    end

    assign gnt      = r_gnt;
    assign slot_idx = r_idx;
    assign slot_vld = r_vld;
    assign rot_cnt  = r_rot;
    assign err      = r_err;

endmodule

// File: tb/tb_ring_slot_ctrl.sv
// Directed bench for ring_slot_ctrl: a vector table for the main sequence plus
// hand sequences for counter wrap (CNT_W=2 instance) and asynchronous reset.
module tb_ring_slot_ctrl;

    logic       clk;
    logic       rst;
    logic [3:0] phase;
    logic [3:0] req;
    logic       clr_err;

    logic [3:0] gnt_a,  gnt_b;
    logic [1:0] idx_a,  idx_b;
    logic       vld_a,  vld_b;
    logic [7:0] rot_a;
    logic [1:0] rot_b;
    logic       err_a,  err_b;

    int checks = 0;
    int errors = 0;

    ring_slot_ctrl #(.N(4), .CNT_W(8)) dut_a (
        .clk(clk), .rst(rst), .phase(phase), .req(req), .clr_err(clr_err),
        .gnt(gnt_a), .slot_idx(idx_a), .slot_vld(vld_a), .rot_cnt(rot_a), .err(err_a)
    );

    ring_slot_ctrl #(.N(4), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .phase(phase), .req(req), .clr_err(clr_err),
        .gnt(gnt_b), .slot_idx(idx_b), .slot_vld(vld_b), .rot_cnt(rot_b), .err(err_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] ph;
        logic [3:0] rq;
        logic       clr;
        logic [3:0] g;
        logic [1:0] idx;
        logic       vld;
        logic [7:0] rot;
        logic       e;
    } vec_t;

    vec_t tbl [25];

    function automatic vec_t mk(logic [3:0] ph, logic [3:0] rq, logic clr, logic [3:0] g,
                                logic [1:0] idx, logic vld, logic [7:0] rot, logic e);
        vec_t v;
        v.ph = ph; v.rq = rq; v.clr = clr; v.g = g;
        v.idx = idx; v.vld = vld; v.rot = rot; v.e = e;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(logic [3:0] ph, logic [3:0] rq, logic clr);
        phase   = ph;
        req     = rq;
        clr_err = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic ring_rot(logic [3:0] rq);
        step(4'b0100, rq, 1'b0);
        step(4'b0010, rq, 1'b0);
        step(4'b0001, rq, 1'b0);
        step(4'b1000, rq, 1'b0);
    endtask

    initial begin
        logic [1:0] wrap_exp [5];
        wrap_exp[0] = 2'd1; wrap_exp[1] = 2'd2; wrap_exp[2] = 2'd3;
        wrap_exp[3] = 2'd0; wrap_exp[4] = 2'd1;

        //          phase    req      clr   gnt      idx  vld   rot  err
        tbl[0]  = mk(4'b0010, 4'b1111, 1'b0, 4'b0000, 2'd0, 1'b0, 8'd0, 1'b0);
        tbl[1]  = mk(4'b0000, 4'b1111, 1'b0, 4'b0000, 2'd0, 1'b0, 8'd0, 1'b0);
        tbl[2]  = mk(4'b1000, 4'b1111, 1'b0, 4'b1000, 2'd3, 1'b1, 8'd0, 1'b0);
        tbl[3]  = mk(4'b0100, 4'b1111, 1'b0, 4'b0100, 2'd2, 1'b1, 8'd0, 1'b0);
        tbl[4]  = mk(4'b0010, 4'b1111, 1'b0, 4'b0010, 2'd1, 1'b1, 8'd0, 1'b0);
        tbl[5]  = mk(4'b0001, 4'b1111, 1'b0, 4'b0001, 2'd0, 1'b1, 8'd0, 1'b0);
        tbl[6]  = mk(4'b1000, 4'b1111, 1'b0, 4'b1000, 2'd3, 1'b1, 8'd1, 1'b0);
        tbl[7]  = mk(4'b0100, 4'b0101, 1'b0, 4'b0100, 2'd2, 1'b1, 8'd1, 1'b0);
        tbl[8]  = mk(4'b0010, 4'b0101, 1'b0, 4'b0000, 2'd1, 1'b1, 8'd1, 1'b0);
        tbl[9]  = mk(4'b0001, 4'b0101, 1'b0, 4'b0001, 2'd0, 1'b1, 8'd1, 1'b0);
        tbl[10] = mk(4'b1000, 4'b0101, 1'b0, 4'b0000, 2'd3, 1'b1, 8'd2, 1'b0);
        tbl[11] = mk(4'b0100, 4'b0101, 1'b0, 4'b0100, 2'd2, 1'b1, 8'd2, 1'b0);
        tbl[12] = mk(4'b0010, 4'b0101, 1'b0, 4'b0000, 2'd1, 1'b1, 8'd2, 1'b0);
        tbl[13] = mk(4'b0001, 4'b0101, 1'b0, 4'b0001, 2'd0, 1'b1, 8'd2, 1'b0);
        tbl[14] = mk(4'b1000, 4'b1111, 1'b0, 4'b1000, 2'd3, 1'b1, 8'd3, 1'b0);
        tbl[15] = mk(4'b0110, 4'b1111, 1'b0, 4'b0000, 2'd0, 1'b0, 8'd3, 1'b1);
        tbl[16] = mk(4'b1000, 4'b1111, 1'b0, 4'b0000, 2'd0, 1'b0, 8'd3, 1'b1);
        tbl[17] = mk(4'b0100, 4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0, 8'd3, 1'b0);
        tbl[18] = mk(4'b0010, 4'b1111, 1'b0, 4'b0000, 2'd0, 1'b0, 8'd3, 1'b0);
        tbl[19] = mk(4'b1000, 4'b1111, 1'b0, 4'b1000, 2'd3, 1'b1, 8'd0, 1'b0);
        tbl[20] = mk(4'b0010, 4'b1111, 1'b0, 4'b0000, 2'd0, 1'b0, 8'd0, 1'b1);
        tbl[21] = mk(4'b0001, 4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0, 8'd0, 1'b0);
        tbl[22] = mk(4'b1000, 4'b1111, 1'b0, 4'b1000, 2'd3, 1'b1, 8'd0, 1'b0);
        tbl[23] = mk(4'b0001, 4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0, 8'd0, 1'b1);
        tbl[24] = mk(4'b0100, 4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0, 8'd0, 1'b0);

        rst     = 1'b0;
        phase   = 4'b0000;
        req     = 4'b0000;
        clr_err = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_gnt", 32'(gnt_a), 32'h0);
        chk("reset_vld", 32'(vld_a), 32'h0);
        chk("reset_idx", 32'(idx_a), 32'h0);
        chk("reset_rot", 32'(rot_a), 32'h0);
        chk("reset_err", 32'(err_a), 32'h0);
        rst = 1'b1;

        for (int k = 0; k < 25; k++) begin
            step(tbl[k].ph, tbl[k].rq, tbl[k].clr);
            chk($sformatf("v%0d_gnt", k), 32'(gnt_a), 32'(tbl[k].g));
            chk($sformatf("v%0d_vld", k), 32'(vld_a), 32'(tbl[k].vld));
            chk($sformatf("v%0d_err", k), 32'(err_a), 32'(tbl[k].e));
            chk($sformatf("v%0d_rot", k), 32'(rot_a), 32'(tbl[k].rot));
            chk($sformatf("v%0d_rot2", k), 32'(rot_b), 32'(tbl[k].rot % 4));
            if (tbl[k].vld)
                chk($sformatf("v%0d_idx", k), 32'(idx_a), 32'(tbl[k].idx));
        end

        // Counter wrap: narrow instance counts 1,2,3,0,1 over five rotations.
        step(4'b1000, 4'b1111, 1'b0);
        chk("wrap_start_rot", 32'(rot_a), 32'h0);
        chk("wrap_start_rot2", 32'(rot_b), 32'h0);
        for (int r = 0; r < 5; r++) begin
            ring_rot(4'b1111);
            chk($sformatf("wrap%0d_rot", r), 32'(rot_a), 32'(r + 1));
            chk($sformatf("wrap%0d_rot2", r), 32'(rot_b), 32'(wrap_exp[r]));
            chk($sformatf("wrap%0d_err2", r), 32'(err_b), 32'h0);
        end

        // Asynchronous reset in the middle of a rotation.
        step(4'b0100, 4'b1111, 1'b0);
        step(4'b0010, 4'b1111, 1'b0);
        chk("pre_rst_gnt", 32'(gnt_a), 32'b0010);
        chk("pre_rst_idx", 32'(idx_a), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_gnt", 32'(gnt_a), 32'h0);
        chk("arst_vld", 32'(vld_a), 32'h0);
        chk("arst_idx", 32'(idx_a), 32'h0);
        chk("arst_rot", 32'(rot_a), 32'h0);
        chk("arst_err", 32'(err_a), 32'h0);
        chk("arst_gnt2", 32'(gnt_b), 32'h0);
        chk("arst_rot2", 32'(rot_b), 32'h0);
        phase = 4'b1000;
        @(posedge clk);
        #1;
        rst = 1'b1;
        step(4'b1000, 4'b1111, 1'b0);
        chk("resync_gnt", 32'(gnt_a), 32'b1000);
        chk("resync_vld", 32'(vld_a), 32'h1);
        chk("resync_idx", 32'(idx_a), 32'd3);
        chk("resync_rot", 32'(rot_a), 32'h0);
        step(4'b0100, 4'b0100, 1'b0);
        chk("resync_next_gnt", 32'(gnt_a), 32'b0100);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
